// File: rtl/adc_capture_ctrl.sv
// Write-side capture controller: armed bursts, decimation and full-drop accounting
// in front of the ADC sample FIFO. Optional ramp source: ADC_CAPTURE_TEST_PATTERN_EN.
module adc_capture_ctrl #(
    parameter int PRECISION   = 10,
    parameter int LEN_WIDTH   = 16,
    parameter int DECIM_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PRECISION-1:0]   adc_code_in,
    input  logic                   arm,
    input  logic                   abort,
    input  logic [LEN_WIDTH-1:0]   capture_len,
    input  logic [DECIM_WIDTH-1:0] decim,
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    input  logic                   test_pattern_sel,
`endif
    input  logic                   fifo_full,
    output logic [PRECISION-1:0]   fifo_din,
    output logic                   fifo_wr_en,
    output logic                   busy,
    output logic                   done,
    output logic [LEN_WIDTH-1:0]   sample_cnt,
    output logic [15:0]            overflow_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LEN_WIDTH-1:0]   r_len_l;
    logic [DECIM_WIDTH-1:0] r_decim_l;
    logic [DECIM_WIDTH-1:0] r_dcnt;
    logic [PRECISION-1:0]   r_d1;
    logic [PRECISION-1:0]   w_d1_src;
    logic [LEN_WIDTH-1:0]   w_cnt_inc;
    logic                   w_arm_acc;
    logic                   w_slot;
    logic                   w_wr;
    logic                   w_drop;
    logic                   w_last;

    assign w_cnt_inc = sample_cnt + LEN_WIDTH'(1);

    // Next-state and per-cycle write/drop decisions; abort always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_arm_acc   = 1'b0;
        w_slot      = 1'b0;
        w_wr        = 1'b0;
        w_drop      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_CAPTURE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_slot = (r_dcnt == DECIM_WIDTH'(0));
                    if (w_slot && fifo_full) begin
                        w_drop = 1'b1;
                    end else if (w_slot) begin
                        w_wr = 1'b1;
                        if ((r_len_l != LEN_WIDTH'(0)) && (w_cnt_inc == r_len_l)) begin
                            w_last      = 1'b1;
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_last = 1'b0;
                        end
                    end else begin
                        w_drop = 1'b0;
                    end
                end
            end
            ST_IDLE, ST_DONE: begin
                if (arm && !abort) begin
                    w_arm_acc   = 1'b1;
                    w_state_nxt = ST_CAPTURE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    logic [PRECISION-1:0] r_ramp;
    logic [PRECISION-1:0] w_ramp_nxt;

    // Ramp advances once per slot so a dropped slot leaves a gap in the written data.
    always_comb begin
        w_ramp_nxt = r_ramp;
        if (w_arm_acc) begin
            w_ramp_nxt = PRECISION'(0);
        end else if (w_slot) begin
            w_ramp_nxt = r_ramp + PRECISION'(1);
        end else begin
            w_ramp_nxt = r_ramp;
        end
        if (test_pattern_sel) begin
            w_d1_src = w_ramp_nxt;
        end else begin
            w_d1_src = adc_code_in;
        end
    end

    // Ramp register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ramp <= PRECISION'(0);
        end else begin
            r_ramp <= w_ramp_nxt;
        end
    end
`else
    assign w_d1_src = adc_code_in;
`endif

    // Input register runs through reset so the data pipe is always primed.
    always_ff @(posedge clk) begin
        r_d1 <= w_d1_src;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latched configuration, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_l      <= LEN_WIDTH'(0);
            r_decim_l    <= DECIM_WIDTH'(0);
            r_dcnt       <= DECIM_WIDTH'(0);
            fifo_din     <= PRECISION'(0);
            fifo_wr_en   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sample_cnt   <= LEN_WIDTH'(0);
            overflow_cnt <= 16'd0;
        end else begin
            fifo_din   <= r_d1;
            fifo_wr_en <= w_wr;
            busy       <= (w_state_nxt == ST_CAPTURE);
            if (w_arm_acc) begin
                r_len_l      <= capture_len;
                r_decim_l    <= decim;
                r_dcnt       <= DECIM_WIDTH'(0);
                done         <= 1'b0;
                sample_cnt   <= LEN_WIDTH'(0);
                overflow_cnt <= 16'd0;
            end else begin
                if (w_wr) begin
                    sample_cnt <= w_cnt_inc;
                end
                if (w_drop && (overflow_cnt != 16'hFFFF)) begin
                    overflow_cnt <= overflow_cnt + 16'd1;
                end
                if (w_last) begin
                    done <= 1'b1;
                end
                // The decimation phase keeps running through dropped slots.
                if ((r_state == ST_CAPTURE) && !abort) begin
                    if (r_dcnt == r_decim_l) begin
                        r_dcnt <= DECIM_WIDTH'(0);
                    end else begin
                        r_dcnt <= r_dcnt + DECIM_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomised and scenario bench for adc_capture_ctrl against a slot-arithmetic reference model.
module tb_adc_capture_ctrl;
    localparam int P  = 10;
    localparam int LW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [P-1:0]  adc_code_in;
    logic          arm;
    logic          abort;
    logic [LW-1:0] capture_len;
    logic [DW-1:0] decim;
    logic          fifo_full;
    logic [P-1:0]  fifo_din;
    logic          fifo_wr_en;
    logic          busy;
    logic          done;
    logic [LW-1:0] sample_cnt;
    logic [15:0]   overflow_cnt;
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    logic          test_pattern_sel;
`endif

    always #5 clk = ~clk;

    adc_capture_ctrl #(.PRECISION(P), .LEN_WIDTH(LW), .DECIM_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .adc_code_in  (adc_code_in),
        .arm          (arm),
        .abort        (abort),
        .capture_len  (capture_len),
        .decim        (decim),
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
        .test_pattern_sel (test_pattern_sel),
`endif
        .fifo_full    (fifo_full),
        .fifo_din     (fifo_din),
        .fifo_wr_en   (fifo_wr_en),
        .busy         (busy),
        .done         (done),
        .sample_cnt   (sample_cnt),
        .overflow_cnt (overflow_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a capture is a run of cycles k=0,1,...; cycle k is a slot when k mod (decim+1) is 0.
    bit m_cap, m_done, m_wr;
    int m_cnt, m_ovf, m_len, m_dec, m_k, m_slot, m_d1, m_din;
    bit tp_now    = 1'b0;
    bit code_ramp = 1'b0;
    int code_next = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        m_wr = 1'b0;
        if (rst) begin
            m_cap = 1'b0; m_done = 1'b0; m_cnt = 0; m_ovf = 0;
        end else if (m_cap) begin
            if (abort) begin
                m_cap = 1'b0;
            end else begin
                if ((m_k % (m_dec + 1)) == 0) begin
                    if (fifo_full) begin
                        if (m_ovf < 65535) m_ovf++;
                    end else begin
                        m_wr  = 1'b1;
                        m_din = tp_now ? (m_slot % (1 << P)) : m_d1;
                        m_cnt = (m_cnt + 1) % (1 << LW);
                        if (m_len != 0 && m_cnt == m_len) begin
                            m_cap  = 1'b0;
                            m_done = 1'b1;
                        end
                    end
                    m_slot++;
                end
                m_k++;
            end
        end else if (arm && !abort) begin
            m_cap = 1'b1; m_len = int'(capture_len); m_dec = int'(decim);
            m_cnt = 0; m_ovf = 0; m_done = 1'b0; m_k = 0; m_slot = 0;
        end
        m_d1 = int'(adc_code_in);
    endtask

    task automatic step(input bit a, input bit ab, input bit f);
        arm       = a;
        abort     = ab;
        fifo_full = f;
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
        test_pattern_sel = tp_now;
`endif
        if (code_ramp) begin
            adc_code_in = P'(code_next);
            code_next++;
        end else begin
            adc_code_in = P'($urandom);
        end
        @(posedge clk);
        model_edge();
        #1;
        check_val("wr_en", 32'(fifo_wr_en), 32'(m_wr));
        check_val("busy", 32'(busy), 32'(m_cap));
        check_val("done", 32'(done), 32'(m_done));
        check_val("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
        check_val("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
        if (m_wr) check_val("fifo_din", 32'(fifo_din), 32'(m_din));
        if (rst) check_val("rst_din", 32'(fifo_din), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        capture_len = LW'($urandom);
        decim       = DW'($urandom);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step($urandom_range(1), $urandom_range(1), $urandom_range(1));
        rst = 1'b0;
        idle(2);

        // Basic burst with a recognisable input ramp starting at 100.
        capture_len = LW'(4); decim = DW'(0);
        code_ramp = 1'b1; code_next = 100;
        step(1'b1, 1'b0, 1'b0);
        idle(6);
        check_val("burst_cnt", 32'(sample_cnt), 32'd4);
        code_ramp = 1'b0;

        capture_len = LW'(3); decim = DW'(2);
        step(1'b1, 1'b0, 1'b0);
        idle(10);

        // FIFO full during slots 2..4.
        capture_len = LW'(4); decim = DW'(0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        idle(5);
        check_val("full_ovf", 32'(overflow_cnt), 32'd3);

        // Abort after two writes, then an arm/abort collision.
        capture_len = LW'(10); decim = DW'(0);
        step(1'b1, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 1'b1, 1'b0);
        check_val("abort_cnt", 32'(sample_cnt), 32'd2);
        step(1'b1, 1'b1, 1'b0);
        check_val("collide_busy", 32'(busy), 32'd0);
        check_val("collide_cnt", 32'(sample_cnt), 32'd2);
        idle(3);

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
        tp_now = 1'b1;
        capture_len = LW'(0); decim = DW'(1);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 12; i++) step(1'b0, 1'b0, i == 5);
        check_val("tp_ovf", 32'(overflow_cnt), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        idle(4);
        step(1'b0, 1'b1, 1'b0);
        tp_now = 1'b0;
        idle(2);
`endif

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            capture_len = LW'($urandom_range(6));
            decim       = DW'($urandom_range(3));
            rst         = ($urandom_range(199) == 0);
            step($urandom_range(9) == 0, $urandom_range(29) == 0, $urandom_range(3) == 0);
        end
        rst = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
